// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through byte FIFO with RTS flow control
module uart_rx_fifo #(
    parameter int BIT_CLK   = 87,
    parameter int DEPTH     = 8,
    parameter int RTS_SLACK = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rxd,
    output logic                     rts,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     frame_err,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BIT_CLK);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CLK / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CLK - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   RTS_LIM   = (AW + 1)'(DEPTH - RTS_SLACK);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state, state_n;
    logic [1:0]    sync;
    logic          rxs, rxs_d;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          push, ferr_n;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wptr, rptr, wptr_n, rptr_n, count_n;
    logic          pop, full, wr;

    assign rxs = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            rxs_d <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            sync  <= {sync[0], rxd};
            rxs_d <= rxs;
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    cnt_n   = HALF_LOAD;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rxs) begin
                        cnt_n   = BIT_LOAD;
                        idx_n   = '0;
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    sh_n  = {rxs, sh[7:1]};
                    cnt_n = BIT_LOAD;
                    idx_n = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign fifo_count = wptr - rptr;
    assign rx_valid   = (fifo_count != '0);
    assign full       = (fifo_count == FULL_CNT);
    assign pop        = rx_valid && rx_ready;
    assign wr         = push && (!full || pop);
    assign wptr_n     = wptr + (AW + 1)'(wr);
    assign rptr_n     = rptr + (AW + 1)'(pop);
    assign count_n    = wptr_n - rptr_n;
    assign rx_data    = rx_valid ? mem[rptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            rts       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            rts       <= (count_n <= RTS_LIM);
            frame_err <= ferr_n;
            overrun   <= push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= sh;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
    localparam int BIT_CLK   = 87;
    localparam int DEPTH     = 8;
    localparam int RTS_SLACK = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rts;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic [3:0] fifo_count;

    uart_rx_fifo #(.BIT_CLK(BIT_CLK), .DEPTH(DEPTH), .RTS_SLACK(RTS_SLACK)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .rts(rts), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .overrun(overrun), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_seen = 0;
    int ovr_seen  = 0;
    int exp_ferr  = 0;
    int exp_ovr   = 0;
    logic [7:0] q[$];

    always @(negedge clk) begin
        if (frame_err) ferr_seen++;
        if (overrun)   ovr_seen++;
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int cycles);
        rxd = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (!stop_ok)              exp_ferr++;
        else if (q.size() == DEPTH) exp_ovr++;
        else                       q.push_back(b);
    endtask

    task automatic pop_one(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
        if (q.size() != 0) begin
            check({tag, "_data"}, 32'(rx_data), 32'(q[0]));
            void'(q.pop_front());
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
        check({tag, "_valid"}, 32'(rx_valid), 32'(q.size() != 0));
        check({tag, "_rts"}, 32'(rts), 32'((DEPTH - q.size()) >= RTS_SLACK));
        check({tag, "_ferr"}, 32'(ferr_seen), 32'(exp_ferr));
        check({tag, "_ovr"}, 32'(ovr_seen), 32'(exp_ovr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rts"}, 32'(rts), 32'd0);
        check({tag, "_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_data"}, 32'(rx_data), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] got_data;
        logic [3:0] got_cnt;

        rst_n = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("rts_after_release", 32'(rts), 32'd1);
        idle(2 * BIT_CLK);

        // single 0xA5 frame with latency measured from the start edge on the pin
        lat = 0; got_data = '0; got_cnt = '0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!rx_valid && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
                got_data = rx_data;
                got_cnt  = fifo_count;
            end
        join
        check("a5_latency_in_window", 32'(lat >= 826 && lat <= 832), 32'd1);
        check("a5_data", 32'(got_data), 32'hA5);
        check("a5_count", 32'(got_cnt), 32'd1);
        pop_one("a5_pop");
        check("a5_valid_after_pop", 32'(rx_valid), 32'd0);

        // fill, rts drop, overrun, in-order drain
        for (int i = 0; i < 8; i++) begin
            send_frame(8'(i), 1'b1);
            check_state($sformatf("fill%0d", i));
        end
        send_frame(8'h08, 1'b1);
        check_state("overrun");
        for (int i = 0; i < 8; i++) pop_one($sformatf("drain%0d", i));
        check_state("drained");

        // full FIFO with a pop on the exact stop-sample edge
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
        fork
            send_frame(8'h20, 1'b1);
            begin
                repeat (828) @(negedge clk);
                pop_one("edge_pop");
            end
        join
        check_state("full_pop");
        for (int i = 0; i < 8; i++) pop_one($sformatf("fp_drain%0d", i));

        // stop bit low followed by a long break, then a clean frame
        send_frame(8'h55, 1'b0);
        repeat (20 * BIT_CLK) @(negedge clk);
        idle(2 * BIT_CLK);
        check_state("break");
        send_frame(8'h3C, 1'b1);
        check_state("after_break");
        pop_one("rx3c");

        // short glitch on an idle line
        rxd = 1'b0;
        repeat (26) @(negedge clk);
        idle(2 * BIT_CLK);
        check_state("glitch");

        // reset mid-frame with three bytes queued
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
        check_state("pre_reset");
        rxd = 1'b0;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        q.delete();
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rts_after_mid_reset", 32'(rts), 32'd1);
        idle(BIT_CLK);
        send_frame(8'hFF, 1'b1);
        check_state("post_reset");
        pop_one("rxff");
        check_state("post_reset_empty");

        // randomized mix of good frames, bad frames, glitches and drains
        for (int it = 0; it < 30; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 7) begin
                send_frame(8'($urandom), 1'b1);
            end else if (kind == 7) begin
                send_frame(8'($urandom), 1'b0);
                idle(BIT_CLK + $urandom_range(0, BIT_CLK));
            end else begin
                rxd = 1'b0;
                repeat ($urandom_range(5, 35)) @(negedge clk);
                idle(BIT_CLK);
            end
            check_state($sformatf("rnd%0d", it));
            if ($urandom_range(0, 2) == 0) begin
                int n;
                n = $urandom_range(0, q.size());
                for (int k = 0; k < n; k++) pop_one($sformatf("rnd%0d_pop", it));
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2 * BIT_CLK));
        end
        while (q.size() != 0) pop_one("final_drain");
        check_state("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receive endpoint. It deserialises 8N1 frames arriving on `rxd` from a peer `uart_core` transmitter and queues the bytes in a first-word-fall-through FIFO. The host drains the FIFO through a valid/ready port. `rts` provides hardware flow control back to the peer's `cts`. The block replaces a bare receiver wherever the host cannot take every byte on the cycle it completes.

## Interface
- `BIT_CLK`, 87: clk cycles per bit; must be ≥ 8.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 4.
- `RTS_SLACK`, 2: `rts` deasserts once free entries < `RTS_SLACK`.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; the block is synchronous to `clk` otherwise.
- `rxd`  in  1  serial input from the peer `txd`; asynchronous, idle high.
- `rts`  out  1  high = ready to receive; connects to the peer `cts`.
- `rx_data`  out  8  FIFO head byte; valid only while `rx_valid` is high.
- `rx_valid`  out  1  FIFO is not empty.
- `rx_ready`  in  1  host accepts the head byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a good frame was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- `rxd` passes through a 2-flop synchroniser. All following references to `rxd` mean the synchronised value `rxs`.
- The FSM has four states: IDLE, START, DATA, STOP, plus WAIT_IDLE.
  - IDLE: a 1→0 transition of `rxs` loads the bit counter with `BIT_CLK/2 - 1` (integer division) and moves to START.
  - START: when the counter reaches 0, sample `rxs`.
    - 0: reload `BIT_CLK-1`, clear the bit index, go to DATA.
    - 1: treat as a glitch, go to IDLE with no flag.
  - DATA: when the counter reaches 0, sample `rxs` into the shift register LSB-first and reload `BIT_CLK-1`. After bit index 7, go to STOP.
  - STOP: when the counter reaches 0, sample `rxs`.
    - 1: push the byte and go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs`=1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- FIFO:
  - Storage is `DEPTH` entries with read and write pointers one bit wider than the address.
  - Pop = `rx_valid && rx_ready`. Push = a good stop bit.
  - Push while full, with no pop: the byte is dropped and `overrun` pulses. The FIFO contents are unchanged.
  - Push while full, with a pop in the same cycle: both are performed and `overrun` is not raised.
  - Push while empty, with a pop in the same cycle: not possible, because `rx_valid` is 0 when the FIFO is empty.
  - `fifo_count` = wptr − rptr, modulo 2·`DEPTH`. Pointers wrap naturally.
- `rts` is registered: it is 1 when `DEPTH − fifo_count ≥ RTS_SLACK` and 0 otherwise. A frame already in flight when `rts` falls is still received.
- `rx_data` is driven from the memory at `rptr`. Its value when `rx_valid`=0 is don't-care, except that it is 0 after reset.

## Timing
- Reset values: `rts`=0, `rx_valid`=0, `rx_data`=0, `frame_err`=0, `overrun`=0, `fifo_count`=0. The FSM is in IDLE, the synchroniser flops hold 1, and the pointers are 0.
- Reset release: `rts` rises on the first `clk` edge after `rst_n` goes high.
- Reset asserted mid-frame: the frame is abandoned and the FIFO is emptied.
- Frame latency: the start edge on the `rxd` pin is seen in `rxs` 2–3 cycles later. The stop sample occurs `BIT_CLK/2 + 9·BIT_CLK` cycles after that edge.
- Stop sample to outputs: the push is registered at the stop-sample edge, so `rx_valid`, `fifo_count` and `rx_data` update on the next cycle. `frame_err` and `overrun` are high for exactly that one cycle.
- Pop: `rx_data` shows the next entry, and `fifo_count` decrements, on the cycle after the pop edge. `rx_valid` drops on that same cycle if the FIFO becomes empty.
- Back-to-back frames: a start bit immediately after the stop sample of the previous frame, with no idle gap, must be received.
- Counters: the bit counter is ≥ $clog2(`BIT_CLK`) bits wide. The sample point tolerates ±4% baud mismatch.

## Test plan
- Drive 0xA5 at `BIT_CLK`=87 from an idle line → `rx_valid` goes high with `rx_data`=0xA5 and `fifo_count`=1. The stop sample falls at 826 ± 3 cycles after the start edge. `rx_ready`=1 → `rx_valid`=0 on the next cycle.
- Send 8 frames (0x00..0x07) with `rx_ready`=0 → `rts` falls when `fifo_count` reaches 7. A 9th frame gives `overrun` for one cycle and `fifo_count` stays 8. Draining then yields 0x00..0x07 in order.
- FIFO full, with a pop on the exact cycle of a new good stop sample → no `overrun`, `fifo_count` stays 8, and the new byte appears last.
- A frame with its stop bit forced low, followed by the line held low for 20 bit times → exactly one `frame_err` and no push. A following valid 0x3C is received correctly.
- A 0.3-bit low glitch on an idle line → no state change beyond START, no flags, `fifo_count`=0.
- Assert `rst_n` low mid-frame with 3 bytes queued → all outputs return to their reset values. After release, `rts`=1 and a new frame 0xFF is received as the only entry.
